// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port memory between
// instruction fetch and load/store, with one registered done pulse per access.
module mem_arbiter #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    localparam int CW = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          last_data_reg, last_data_next;   // 0 = fetch was last granted
    logic          gnt_data_reg, gnt_data_next;
    logic          we_reg, we_next;
    logic          mem_en_reg, mem_en_next;
    logic          mem_we_reg, mem_we_next;
    logic [31:0]   mem_addr_reg, mem_addr_next;
    logic [31:0]   mem_wdata_reg, mem_wdata_next;
    logic [3:0]    mem_wstrb_reg, mem_wstrb_next;
    logic          if_done_reg, if_done_next;
    logic          d_done_reg, d_done_next;
    logic [31:0]   if_rdata_reg, if_rdata_next;
    logic [31:0]   d_rdata_reg, d_rdata_next;
    logic          busy_reg, busy_next;

    logic grant;
    logic win_data;
    logic last_wait;

    assign grant     = (state_reg == IDLE) && (if_req || d_req);
    assign win_data  = d_req && (!if_req || !last_data_reg);
    assign last_wait = (state_reg == WAIT) && (cnt_reg == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            last_data_reg <= 1'b0;
            gnt_data_reg  <= 1'b0;
            we_reg        <= 1'b0;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= 32'h0;
            mem_wdata_reg <= 32'h0;
            mem_wstrb_reg <= 4'h0;
            if_done_reg   <= 1'b0;
            d_done_reg    <= 1'b0;
            if_rdata_reg  <= 32'h0;
            d_rdata_reg   <= 32'h0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            last_data_reg <= last_data_next;
            gnt_data_reg  <= gnt_data_next;
            we_reg        <= we_next;
            mem_en_reg    <= mem_en_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_wstrb_reg <= mem_wstrb_next;
            if_done_reg   <= if_done_next;
            d_done_reg    <= d_done_next;
            if_rdata_reg  <= if_rdata_next;
            d_rdata_reg   <= d_rdata_next;
            busy_reg      <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE:  if (grant) state_next = ISSUE;
            ISSUE: begin
                state_next = WAIT;
                cnt_next   = CW'(MEM_LATENCY);
            end
            WAIT: begin
                cnt_next = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Every output is computed one cycle ahead so that it is registered
    // and lines up with the state it belongs to.
    always_comb begin
        last_data_next = last_data_reg;
        gnt_data_next  = gnt_data_reg;
        we_next        = we_reg;
        mem_en_next    = 1'b0;
        mem_we_next    = 1'b0;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_wstrb_next = 4'h0;
        if_rdata_next  = if_rdata_reg;
        d_rdata_next   = d_rdata_reg;
        if (grant) begin
            last_data_next = win_data;
            gnt_data_next  = win_data;
            we_next        = win_data && d_we;
            mem_en_next    = 1'b1;
            mem_we_next    = win_data && d_we;
            mem_addr_next  = (win_data ? d_addr : if_addr) & 32'hFFFF_FFFC;
            mem_wdata_next = win_data ? d_wdata : 32'h0;
            mem_wstrb_next = (win_data && d_we) ? d_wstrb : 4'h0;
        end
        if (last_wait) begin
            if (!gnt_data_reg)
                if_rdata_next = mem_rdata;
            else if (!we_reg)
                d_rdata_next = mem_rdata;
        end
        if_done_next = (state_next == DONE) && !gnt_data_reg;
        d_done_next  = (state_next == DONE) && gnt_data_reg;
        busy_next    = (state_next != IDLE);
    end

    assign if_done   = if_done_reg;
    assign if_rdata  = if_rdata_reg;
    assign d_done    = d_done_reg;
    assign d_rdata   = d_rdata_reg;
    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_wstrb = mem_wstrb_reg;
    assign busy      = busy_reg;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one fixed-latency, single-port, word-wide memory between the instruction-fetch path and the load/store path of the rv32i core.
- Sequences each access through a small FSM and returns read data to the winning requester with a one-cycle done pulse.
- Sits between the core datapath (fetch/LSU) and the unified memory inside top. The core stalls on a port until that port's done pulse.

Parameters:
- MEM_LATENCY, 1, cycles from the mem_en cycle to the cycle mem_rdata is valid; legal range >=1. The cycle counter is $clog2(MEM_LATENCY+1) bits wide.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_done
- if_addr  in  32  fetch byte address
- if_done  out  1  one-cycle pulse, fetch complete
- if_rdata  out  32  fetched word; held until the next if_done
- d_req  in  1  data request; held until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_wstrb  in  4  store byte enables
- d_done  out  1  one-cycle pulse, data access complete
- d_rdata  out  32  load word; held until the next load's d_done
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_we  out  1  memory write enable
- mem_addr  out  32  word address: {addr[31:2], 2'b00}
- mem_wdata  out  32  write data
- mem_wstrb  out  4  byte enables; 0 for fetches and loads
- mem_rdata  in  32  read data, valid MEM_LATENCY cycles after the mem_en cycle
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (synchronous): applies on any clk edge with rst=1, including mid-transaction.
  - State goes to IDLE. last_grant goes to FETCH.
  - mem_en, mem_we, if_done, d_done and busy are 0. mem_addr, mem_wdata, mem_wstrb, if_rdata and d_rdata are 32'h0 / 4'h0.
  - Any in-flight transaction is dropped and produces no done pulse.
- All outputs are registered.
- FSM states: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - With no request, stay in IDLE.
  - With any request, grant it, latch addr/we/wdata/wstrb from the winner and go to ISSUE.
- Arbitration in IDLE:
  - Only d_req: data wins. Only if_req: fetch wins.
  - Both: the port not in last_grant wins (round-robin on tie).
  - Because last_grant resets to FETCH, the first tie after reset goes to data.
  - last_grant updates on every grant.
- ISSUE (1 cycle):
  - mem_en=1. mem_we=d_we for a data grant, 0 for a fetch.
  - mem_addr is the latched address with bits [1:0] forced to 0.
  - mem_wstrb is the latched d_wstrb for a store, else 0.
  - Next state is WAIT; counter loads MEM_LATENCY.
- WAIT (MEM_LATENCY cycles):
  - mem_en=0; the counter decrements each cycle.
  - In the last WAIT cycle (counter==1), mem_rdata is captured: into if_rdata for a fetch, into d_rdata for a load. Stores leave d_rdata unchanged.
  - Next state is DONE.
- DONE (1 cycle):
  - Pulse the granted port's done for exactly one cycle.
  - Requests are not sampled in this cycle. The requester drops or changes its req by the next cycle; a req still high in the following IDLE cycle is a new transaction.
- Timing: for a grant in IDLE cycle T:
  - mem_en is high in T+1.
  - mem_rdata is sampled in T+1+MEM_LATENCY.
  - done is high in T+2+MEM_LATENCY.
  - The earliest next grant is T+3+MEM_LATENCY. Throughput is one access per MEM_LATENCY+3 cycles.
- Request inputs changing after the grant have no effect on the transaction in progress.
- Never more than one mem_en per transaction. if_done and d_done are never high in the same cycle.
- Misaligned addresses are not trapped here; the low two bits are simply dropped on mem_addr.

Test Plan:
- Reset: rst=1 for 2 cycles with if_req=1 -> while rst=1, busy=0, mem_en=0, if_done=0. After release, first grant in the first IDLE cycle.
- Single fetch, MEM_LATENCY=1: if_req=1, if_addr=32'h0000_0006 granted at T -> mem_en=1, mem_addr=32'h0000_0004, mem_we=0 at T+1. Memory returns 32'h0010_0093 at T+2 -> if_done=1, if_rdata=32'h0010_0093 at T+3.
- Store: d_req=1, d_we=1, d_addr=32'h100, d_wdata=32'hDEAD_BEEF, d_wstrb=4'b0011 -> at ISSUE mem_we=1, mem_wstrb=4'b0011, mem_wdata=32'hDEAD_BEEF. d_done follows after MEM_LATENCY+1 further cycles; d_rdata is unchanged.
- Tie after reset: if_req and d_req both high, both held -> order is data, fetch, data, fetch. Each done comes MEM_LATENCY+3 cycles after the previous one.
- Latency 3: with MEM_LATENCY=3, a load issued at T+1 -> d_rdata captures mem_rdata from T+4. d_done=1 only at T+5.
- Reset mid-op: assert rst during WAIT of a fetch -> no if_done. Next cycle IDLE, busy=0, if_rdata=0.
